// File: rtl/ex_operand_stage_pkg.sv
// Shared definitions for the ID/EX operand stage: ALU opcode encodings
// (mirrors the core-wide Parameters.v constants) and the bubble opcode.
package ex_operand_stage_pkg;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_SRA  = 4'd2,
    ALU_ADD  = 4'd3,
    ALU_SUB  = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_AND  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_LUI  = 4'd10
  } alu_op_e;

  // A bubble executes as a harmless ADD of zeros.
  localparam logic [3:0] BUBBLE_ALU_CTRL = ALU_ADD;

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Operand forwarding mux: picks the freshest value of one source register
// from MEM, then WB, then the ID/EX-registered register-file read.
module fwd_mux
  import ex_operand_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic [REGW-1:0] idx,
  input  logic [XLEN-1:0] reg_val,
  input  logic [REGW-1:0] mem_rd,
  input  logic            mem_we,
  input  logic [XLEN-1:0] mem_result,
  input  logic [REGW-1:0] wb_rd,
  input  logic            wb_we,
  input  logic [XLEN-1:0] wb_result,
  output logic [XLEN-1:0] fwd
);

  logic mem_hit;
  logic wb_hit;

  // x0 is hardwired zero, so a write targeting it must never be forwarded.
  assign mem_hit = mem_we && (mem_rd != {REGW{1'b0}}) && (mem_rd == idx);
  assign wb_hit  = wb_we  && (wb_rd  != {REGW{1'b0}}) && (wb_rd  == idx);

  // MEM holds the younger result, so it beats WB.
  always_comb begin
    fwd = reg_val;
    if (mem_hit) begin
      fwd = mem_result;
    end else if (wb_hit) begin
      fwd = wb_result;
    end else begin
      fwd = reg_val;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use
// hazard detection, feeding the ALU directly.
module ex_operand_stage
  import ex_operand_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic [REGW-1:0] id_rd,
  input  logic [XLEN-1:0] id_rs1_val,
  input  logic [XLEN-1:0] id_rs2_val,
  input  logic [XLEN-1:0] id_imm,
  input  logic [3:0]      id_alu_ctrl,
  input  logic            id_op1_sel,
  input  logic            id_op2_sel,
  input  logic            id_reg_write,
  input  logic            id_is_load,
  input  logic [REGW-1:0] mem_rd,
  input  logic            mem_reg_write,
  input  logic [XLEN-1:0] mem_result,
  input  logic [REGW-1:0] wb_rd,
  input  logic            wb_reg_write,
  input  logic [XLEN-1:0] wb_result,
  output logic [XLEN-1:0] Operand1,
  output logic [XLEN-1:0] Operand2,
  output logic [3:0]      AluContrl,
  output logic            ex_valid,
  output logic            ex_reg_write,
  output logic            ex_is_load,
  output logic [REGW-1:0] ex_rd,
  output logic [XLEN-1:0] ex_store_data,
  output logic            load_use_hazard
);

  logic [XLEN-1:0] ex_pc;
  logic [REGW-1:0] ex_rs1;
  logic [REGW-1:0] ex_rs2;
  logic [XLEN-1:0] ex_rs1_val;
  logic [XLEN-1:0] ex_rs2_val;
  logic [XLEN-1:0] ex_imm;
  logic [3:0]      ex_alu_ctrl;
  logic            ex_op1_sel;
  logic            ex_op2_sel;
  logic [XLEN-1:0] fwd1;
  logic [XLEN-1:0] fwd2;

  // ID/EX bank: reset and flush both load a bubble and override stall.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_is_load   <= 1'b0;
      ex_rd        <= {REGW{1'b0}};
      ex_rs1       <= {REGW{1'b0}};
      ex_rs2       <= {REGW{1'b0}};
      ex_pc        <= {XLEN{1'b0}};
      ex_rs1_val   <= {XLEN{1'b0}};
      ex_rs2_val   <= {XLEN{1'b0}};
      ex_imm       <= {XLEN{1'b0}};
      ex_alu_ctrl  <= BUBBLE_ALU_CTRL;
      ex_op1_sel   <= 1'b0;
      ex_op2_sel   <= 1'b0;
    end else if (!stall) begin
      ex_valid     <= id_valid;
      ex_reg_write <= id_reg_write;
      ex_is_load   <= id_is_load;
      ex_rd        <= id_rd;
      ex_rs1       <= id_rs1;
      ex_rs2       <= id_rs2;
      ex_pc        <= id_pc;
      ex_rs1_val   <= id_rs1_val;
      ex_rs2_val   <= id_rs2_val;
      ex_imm       <= id_imm;
      ex_alu_ctrl  <= id_alu_ctrl;
      ex_op1_sel   <= id_op1_sel;
      ex_op2_sel   <= id_op2_sel;
    end
  end

  fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd_rs1 (
    .idx        (ex_rs1),
    .reg_val    (ex_rs1_val),
    .mem_rd     (mem_rd),
    .mem_we     (mem_reg_write),
    .mem_result (mem_result),
    .wb_rd      (wb_rd),
    .wb_we      (wb_reg_write),
    .wb_result  (wb_result),
    .fwd        (fwd1)
  );

  fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd_rs2 (
    .idx        (ex_rs2),
    .reg_val    (ex_rs2_val),
    .mem_rd     (mem_rd),
    .mem_we     (mem_reg_write),
    .mem_result (mem_result),
    .wb_rd      (wb_rd),
    .wb_we      (wb_reg_write),
    .wb_result  (wb_result),
    .fwd        (fwd2)
  );

  assign Operand1      = ex_op1_sel ? ex_pc  : fwd1;
  assign Operand2      = ex_op2_sel ? ex_imm : fwd2;
  assign ex_store_data = fwd2;
  assign AluContrl     = ex_alu_ctrl;

  // Conservative: selects are ignored, any index match against a load stalls.
  assign load_use_hazard = ex_valid && ex_is_load && (ex_rd != {REGW{1'b0}}) &&
                           id_valid && ((id_rs1 == ex_rd) || (id_rs2 == ex_rd));

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: a vector table driven through a
// scoreboard queue, plus hand-written hazard/stall/flush/reset sequences.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_val, id_rs2_val, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_ctrl;
  logic        id_op1_sel, id_op2_sel, id_reg_write, id_is_load;
  logic [4:0]  mem_rd, wb_rd;
  logic        mem_reg_write, wb_reg_write;
  logic [31:0] mem_result, wb_result;
  logic [31:0] Operand1, Operand2, ex_store_data;
  logic [3:0]  AluContrl;
  logic        ex_valid, ex_reg_write, ex_is_load, load_use_hazard;
  logic [4:0]  ex_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_operand_stage #(.XLEN(32), .REGW(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
    .id_alu_ctrl(id_alu_ctrl), .id_op1_sel(id_op1_sel), .id_op2_sel(id_op2_sel),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .Operand1(Operand1), .Operand2(Operand2), .AluContrl(AluContrl),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .ex_store_data(ex_store_data), .load_use_hazard(load_use_hazard)
  );

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rs1_val, rs2_val, imm;
    logic [3:0]  ctrl;
    logic        op1_sel, op2_sel, rw, ld;
    logic [4:0]  mrd;
    logic        mwe;
    logic [31:0] mres;
    logic [4:0]  wrd;
    logic        wwe;
    logic [31:0] wres;
    logic [31:0] e_op1, e_op2, e_store;
    logic        e_haz;
  } vec_t;

  typedef struct {
    logic [31:0] op1, op2, store;
    logic [3:0]  ctrl;
    logic        valid, rw, ld, haz;
    logic [4:0]  rd;
  } exp_t;

  vec_t vecs[9];
  exp_t sb[$];

  function automatic vec_t mkv(
    input logic v, input logic [31:0] pc, input logic [4:0] rs1, rs2, rd,
    input logic [31:0] r1v, r2v, imm, input logic [3:0] ctrl,
    input logic s1, s2, rw, ld,
    input logic [4:0] mrd, input logic mwe, input logic [31:0] mres,
    input logic [4:0] wrd, input logic wwe, input logic [31:0] wres,
    input logic [31:0] e1, e2, es, input logic eh);
    vec_t r;
    r.valid = v; r.pc = pc; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd;
    r.rs1_val = r1v; r.rs2_val = r2v; r.imm = imm; r.ctrl = ctrl;
    r.op1_sel = s1; r.op2_sel = s2; r.rw = rw; r.ld = ld;
    r.mrd = mrd; r.mwe = mwe; r.mres = mres; r.wrd = wrd; r.wwe = wwe; r.wres = wres;
    r.e_op1 = e1; r.e_op2 = e2; r.e_store = es; r.e_haz = eh;
    return r;
  endfunction

  task automatic apply(input vec_t v);
    id_valid = v.valid; id_pc = v.pc; id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd;
    id_rs1_val = v.rs1_val; id_rs2_val = v.rs2_val; id_imm = v.imm;
    id_alu_ctrl = v.ctrl; id_op1_sel = v.op1_sel; id_op2_sel = v.op2_sel;
    id_reg_write = v.rw; id_is_load = v.ld;
    mem_rd = v.mrd; mem_reg_write = v.mwe; mem_result = v.mres;
    wb_rd = v.wrd; wb_reg_write = v.wwe; wb_result = v.wres;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, " Operand1"}, Operand1, e.op1);
    chk({tag, " Operand2"}, Operand2, e.op2);
    chk({tag, " store"}, ex_store_data, e.store);
    chk({tag, " AluContrl"}, {28'd0, AluContrl}, {28'd0, e.ctrl});
    chk({tag, " ex_valid"}, {31'd0, ex_valid}, {31'd0, e.valid});
    chk({tag, " ex_reg_write"}, {31'd0, ex_reg_write}, {31'd0, e.rw});
    chk({tag, " ex_is_load"}, {31'd0, ex_is_load}, {31'd0, e.ld});
    chk({tag, " ex_rd"}, {27'd0, ex_rd}, {27'd0, e.rd});
    chk({tag, " hazard"}, {31'd0, load_use_hazard}, {31'd0, e.haz});
  endtask

  initial begin
    exp_t e;
    exp_t rst_exp;
    vec_t va, vb, vl;

    rst_exp.op1 = 32'd0; rst_exp.op2 = 32'd0; rst_exp.store = 32'd0; rst_exp.ctrl = 4'd3;
    rst_exp.valid = 1'b0; rst_exp.rw = 1'b0; rst_exp.ld = 1'b0; rst_exp.rd = 5'd0; rst_exp.haz = 1'b0;

    //                v     pc            rs1    rs2    rd     rs1_val        rs2_val        imm            ctrl   s1    s2    rw    ld    mrd    mwe   mres           wrd    wwe   wres           e_op1          e_op2          e_store        haz
    vecs[0] = mkv(1'b1, 32'h0000_0100, 5'd1,  5'd2,  5'd4,  32'd7,         32'd9,         32'd5,         4'd3,  1'b0, 1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 32'd0,         5'd0,  1'b0, 32'd0,         32'd7,         32'd5,         32'd9,         1'b0);
    vecs[1] = mkv(1'b1, 32'h0000_0200, 5'd3,  5'd6,  5'd7,  32'h11,        32'h22,        32'h0,         4'd4,  1'b1, 1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 32'd0,         5'd0,  1'b0, 32'd0,         32'h200,       32'h22,        32'h22,        1'b0);
    vecs[2] = mkv(1'b1, 32'h0000_0204, 5'd3,  5'd8,  5'd9,  32'h1,         32'h33,        32'h10,        4'd3,  1'b0, 1'b1, 1'b1, 1'b0, 5'd3,  1'b1, 32'hAAAA,      5'd3,  1'b1, 32'hBBBB,      32'hAAAA,      32'h10,        32'h33,        1'b0);
    vecs[3] = mkv(1'b1, 32'h0000_0208, 5'd3,  5'd8,  5'd9,  32'h1,         32'h33,        32'h10,        4'd3,  1'b0, 1'b1, 1'b1, 1'b0, 5'd3,  1'b0, 32'hAAAA,      5'd3,  1'b1, 32'hBBBB,      32'hBBBB,      32'h10,        32'h33,        1'b0);
    vecs[4] = mkv(1'b1, 32'h0000_020C, 5'd2,  5'd0,  5'd1,  32'h55,        32'h0,         32'h0,         4'd5,  1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  1'b1, 32'hFFFF_FFFF, 5'd0,  1'b1, 32'h1234,      32'h55,        32'h0,         32'h0,         1'b0);
    vecs[5] = mkv(1'b1, 32'h0000_0210, 5'd10, 5'd9,  5'd11, 32'h1,         32'h66,        32'h77,        4'd7,  1'b0, 1'b1, 1'b0, 1'b0, 5'd10, 1'b1, 32'hDEAD,      5'd9,  1'b1, 32'hCAFE,      32'hDEAD,      32'h77,        32'hCAFE,      1'b0);
    vecs[6] = mkv(1'b0, 32'h0000_0214, 5'd12, 5'd13, 5'd12, 32'h121,       32'h131,       32'h0,         4'd6,  1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 32'd0,         5'd0,  1'b0, 32'd0,         32'h121,       32'h131,       32'h131,       1'b0);
    vecs[7] = mkv(1'b1, 32'h0000_0218, 5'd5,  5'd1,  5'd5,  32'h1000,      32'h2,         32'h8,         4'd3,  1'b0, 1'b1, 1'b1, 1'b1, 5'd0,  1'b0, 32'd0,         5'd0,  1'b0, 32'd0,         32'h1000,      32'h8,         32'h2,         1'b1);
    vecs[8] = mkv(1'b1, 32'h0000_021C, 5'd4,  5'd4,  5'd14, 32'h44,        32'h45,        32'h0,         4'd8,  1'b0, 1'b0, 1'b1, 1'b0, 5'd4,  1'b0, 32'h999,       5'd4,  1'b0, 32'h888,       32'h44,        32'h45,        32'h45,        1'b0);

    va = mkv(1'b1, 32'h300, 5'd11, 5'd12, 5'd13, 32'h1111, 32'h2222, 32'h3333, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0,
             5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    vb = mkv(1'b1, 32'h400, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h4, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0,
             5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);

    // Reset with non-trivial ID inputs present.
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    apply(va);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk_all("reset", rst_exp);
    rst = 1'b0;

    // Table: push expectation on drive, pop and compare one cycle later.
    for (int i = 0; i < 9; i++) begin
      apply(vecs[i]);
      e.op1 = vecs[i].e_op1; e.op2 = vecs[i].e_op2; e.store = vecs[i].e_store;
      e.ctrl = vecs[i].ctrl; e.valid = vecs[i].valid; e.rw = vecs[i].rw;
      e.ld = vecs[i].ld; e.rd = vecs[i].rd; e.haz = vecs[i].e_haz;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard underflow at vector %0d", i);
      end else begin
        e = sb.pop_front();
        chk_all($sformatf("vec%0d", i), e);
      end
    end

    // Load-use: load rd=5 in EX, ID reads x5 via rs2.
    vl = mkv(1'b1, 32'h500, 5'd1, 5'd2, 5'd5, 32'h0, 32'h0, 32'h0, 4'd3, 1'b0, 1'b1, 1'b1, 1'b1,
             5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    apply(vl);
    @(posedge clk); @(negedge clk);
    id_rs1 = 5'd1; id_rs2 = 5'd5; id_valid = 1'b1; id_is_load = 1'b0;
    #1 chk("lu rs2 match", {31'd0, load_use_hazard}, 32'd1);
    id_valid = 1'b0;
    #1 chk("lu id invalid", {31'd0, load_use_hazard}, 32'd0);
    vl.rd = 5'd0;
    apply(vl);
    @(posedge clk); @(negedge clk);
    id_rs1 = 5'd1; id_rs2 = 5'd0; id_valid = 1'b1; id_is_load = 1'b0;
    #1 chk("lu rd x0", {31'd0, load_use_hazard}, 32'd0);

    // Stall for three cycles with changing ID inputs; forwarding still tracks.
    @(negedge clk);
    apply(va);
    @(posedge clk); @(negedge clk);
    chk("pre-stall Operand1", Operand1, 32'h1111);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      id_pc = 32'h900 + k; id_rs1 = 5'd20 + k[4:0]; id_rd = 5'd21; id_rs1_val = $urandom;
      id_rs2_val = $urandom; id_alu_ctrl = 4'd9; id_valid = 1'b0; id_op1_sel = 1'b1;
      mem_rd = 5'd11; mem_reg_write = (k == 2); mem_result = 32'h5A5A;
      @(posedge clk); @(negedge clk);
      chk($sformatf("stall%0d Operand1", k), Operand1, (k == 2) ? 32'h5A5A : 32'h1111);
      chk($sformatf("stall%0d Operand2", k), Operand2, 32'h2222);
      chk($sformatf("stall%0d AluContrl", k), {28'd0, AluContrl}, 32'd6);
      chk($sformatf("stall%0d ex_rd", k), {27'd0, ex_rd}, 32'd13);
      chk($sformatf("stall%0d ex_valid", k), {31'd0, ex_valid}, 32'd1);
    end
    mem_reg_write = 1'b0;
    flush = 1'b1;
    @(posedge clk); @(negedge clk);
    chk_all("flush+stall", rst_exp);
    flush = 1'b0; stall = 1'b0;

    // Reset mid-stream while stalled, then resume loading.
    apply(va);
    @(posedge clk); @(negedge clk);
    chk("pre-rst ex_valid", {31'd0, ex_valid}, 32'd1);
    rst = 1'b1; stall = 1'b1;
    @(posedge clk); @(negedge clk);
    chk_all("rst during stall", rst_exp);
    rst = 1'b0; stall = 1'b0;
    apply(vb);
    @(posedge clk); @(negedge clk);
    chk("post-rst Operand1", Operand1, 32'h400);
    chk("post-rst Operand2", Operand2, 32'h2);
    chk("post-rst AluContrl", {28'd0, AluContrl}, 32'd4);
    chk("post-rst ex_valid", {31'd0, ex_valid}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
